// File: rtl/jtag_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : jtag_pkg                                                         |
// | Purpose  : Shared TAP state encoding, default IR width and instruction      |
// |            opcodes for the JTAG IR/DR chain.                                |
// | Contents : tap_ctrl_fsm_t, IR_WIDTH_DEFAULT, OPC_IDCODE, OPC_USER,          |
// |            is_shift_state()                                                 |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR_SCAN   = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR_SCAN   = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_ctrl_fsm_t;

  localparam int IR_WIDTH_DEFAULT = 4;

  // BYPASS is all ones at whatever IR width is in use, so it is built
  // from '1 where the width is known rather than stored here.
  localparam int OPC_IDCODE = 1;
  localparam int OPC_USER   = 2;

  function automatic logic is_shift_state(input tap_ctrl_fsm_t s);
    return (s == SHIFT_IR) || (s == SHIFT_DR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_dr_shift.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : jtag_dr_shift                                                    |
// | Purpose  : Generic JTAG data shift register: parallel load at capture,      |
// |            right shift with tdi entering the MSB, hold otherwise.           |
// | Ports    : tck, trstn (async active-low), capture, shift, tdi,              |
// |            load_data[WIDTH-1:0], data[WIDTH-1:0] (bit 0 is serial out)     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module jtag_dr_shift #(
  parameter int WIDTH = 32
) (
  input  logic             tck,
  input  logic             trstn,
  input  logic             capture,
  input  logic             shift,
  input  logic             tdi,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] shifted;

  // A one-bit register has no upper slice to carry forward.
  if (WIDTH == 1) begin : g_single
    assign shifted = tdi;
  end else begin : g_multi
    assign shifted = {tdi, data[WIDTH-1:1]};
  end

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      data <= '0;
    end else if (capture) begin
      data <= load_data;
    end else if (shift) begin
      data <= shifted;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtag_ir_dr_chain.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : jtag_ir_dr_chain                                                 |
// | Purpose  : JTAG instruction register plus BYPASS / IDCODE / USER data       |
// |            registers, driven by the registered TAP state.                   |
// | Ports    : tck, trstn (async active-low), tap_state, tdi, tdo, tdo_en,      |
// |            ir_q, user_capture_data, user_update_data, user_update          |
// | Config   : JTAG_IDCODE_EN - include the IDCODE register and make IDCODE    |
// |            the reset instruction; otherwise BYPASS is the reset            |
// |            instruction and opcode 1 decodes as bypass.                     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module jtag_ir_dr_chain
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH      = IR_WIDTH_DEFAULT,
  parameter int          USER_DR_WIDTH = 32,
  parameter logic [31:0] IDCODE_VALUE  = 32'h1BEE_F001
) (
  input  logic                     tck,
  input  logic                     trstn,
  input  tap_ctrl_fsm_t            tap_state,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic [IR_WIDTH-1:0]      ir_q,
  input  logic [USER_DR_WIDTH-1:0] user_capture_data,
  output logic [USER_DR_WIDTH-1:0] user_update_data,
  output logic                     user_update
);

  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(OPC_IDCODE);
  localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(OPC_USER);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_IR  = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RESET_IR  = OP_BYPASS;
`endif

  logic [IR_WIDTH-1:0]      ir_shift;
  logic                     bypass;
  logic [USER_DR_WIDTH-1:0] user_shift;
  logic                     sel_user;
  logic                     capture_dr;
  logic                     shift_dr;
  logic                     dr_bit;

  // Instruction register: ir_q only moves in UPDATE_IR / TEST_LOGIC_RESET,
  // so the DR selection is frozen for the whole of any DR scan.
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      ir_shift <= '0;
      ir_q     <= RESET_IR;
    end else begin
      case (tap_state)
        TEST_LOGIC_RESET: ir_q     <= RESET_IR;
        CAPTURE_IR:       ir_shift <= IR_WIDTH'(1);
        SHIFT_IR:         ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
        UPDATE_IR:        ir_q     <= ir_shift;
        default:          ;
      endcase
    end
  end

  assign sel_user   = (ir_q == OP_USER);
  assign capture_dr = (tap_state == CAPTURE_DR);
  assign shift_dr   = (tap_state == SHIFT_DR);

`ifdef JTAG_IDCODE_EN
  logic        sel_idcode;
  logic [31:0] id_shift;
  logic        unused_id_upper;

  assign sel_idcode = (ir_q == OP_IDCODE);
  // Only the serial end of the ID register is ever observed.
  assign unused_id_upper = ^id_shift[31:1];

  jtag_dr_shift #(
    .WIDTH (32)
  ) u_id_shift (
    .tck       (tck),
    .trstn     (trstn),
    .capture   (capture_dr && sel_idcode),
    .shift     (shift_dr && sel_idcode),
    .tdi       (tdi),
    .load_data (IDCODE_VALUE),
    .data      (id_shift)
  );
`else
  logic sel_idcode;
  logic unused_idcode;

  // Opcode 1 falls through to bypass when no ID register is built.
  assign sel_idcode    = 1'b0;
  assign unused_idcode = ^IDCODE_VALUE;
`endif

  jtag_dr_shift #(
    .WIDTH (USER_DR_WIDTH)
  ) u_user_shift (
    .tck       (tck),
    .trstn     (trstn),
    .capture   (capture_dr && sel_user),
    .shift     (shift_dr && sel_user),
    .tdi       (tdi),
    .load_data (user_capture_data),
    .data      (user_shift)
  );

  // Bypass catches every opcode that is neither USER nor (enabled) IDCODE.
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      bypass <= 1'b0;
    end else if (!sel_user && !sel_idcode) begin
      if (capture_dr) begin
        bypass <= 1'b0;
      end else if (shift_dr) begin
        bypass <= tdi;
      end
    end
  end

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      user_update_data <= '0;
      user_update      <= 1'b0;
    end else begin
      user_update <= (tap_state == UPDATE_DR) && sel_user;
      if ((tap_state == UPDATE_DR) && sel_user) begin
        user_update_data <= user_shift;
      end
    end
  end

  always_comb begin
    dr_bit = bypass;
`ifdef JTAG_IDCODE_EN
    if (sel_idcode) begin
      dr_bit = id_shift[0];
    end
`endif
    if (sel_user) begin
      dr_bit = user_shift[0];
    end
  end

  // While reset is held the chain is not in a shift state, so the serial
  // output is forced quiet regardless of what tap_state shows.
  always_comb begin
    tdo    = 1'b0;
    tdo_en = 1'b0;
    if (trstn && is_shift_state(tap_state)) begin
      tdo_en = 1'b1;
      tdo    = (tap_state == SHIFT_IR) ? ir_shift[0] : dr_bit;
    end
  end

endmodule
`default_nettype wire
